// File: rtl/adder_share_ctrl.sv
// -----------------------------------------------------------------------------
// adder_share_ctrl
//
// Time-shares one 30-bit adder between NREQ requesters. A round-robin arbiter
// picks one request at a time; narrow (30-bit) requests take a single adder
// pass, wide (60-bit) requests take two passes (low half, then high half with
// the low-half carry forwarded). The result is returned on one response
// channel tagged with the requester index.
//
// Handshake rule for both channels: a transfer happens on a rising clk edge
// where valid and ready are both 1. req_ready is one-hot or zero and is only
// raised in IDLE. rsp_* payload is held stable while rsp_valid=1 and
// rsp_ready=0.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   req_valid  [NREQ]     request valid, one bit per requester
//   req_ready  [NREQ]     request accepted (one-hot or zero)
//   req_a      [NREQ*60]  operand A, requester i at [60i+59:60i]
//   req_b      [NREQ*60]  operand B, same packing
//   req_cin    [NREQ]     carry-in per requester
//   req_wide   [NREQ]     1 = 60-bit add, 0 = 30-bit add on bits [29:0]
//   rsp_valid             response valid
//   rsp_ready             response consumer ready
//   rsp_id     [IDW]      requester being answered
//   rsp_sum    [60]       sum; [59:30] zero for narrow requests
//   rsp_cout              carry-out of the final pass
//   dbg_state  [2]        FSM state: 0=IDLE 1=LO 2=HI 3=RESP
// -----------------------------------------------------------------------------

// Shared 30-bit adder.
module adder (
    input  logic [29:0] a,
    input  logic [29:0] b,
    input  logic        cin,
    output logic [29:0] sum,
    output logic        cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {30'b0, cin};
endmodule

module adder_share_ctrl #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*60-1:0]   req_a,
    input  logic [NREQ*60-1:0]   req_b,
    input  logic [NREQ-1:0]      req_cin,
    input  logic [NREQ-1:0]      req_wide,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [59:0]          rsp_sum,
    output logic                 rsp_cout,
    output logic [1:0]           dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next_state;

    logic [IDW-1:0]  r_rr_ptr;
    logic [59:0]     r_a;
    logic [59:0]     r_b;
    logic            r_cin;
    logic            r_wide;
    logic [IDW-1:0]  r_id;
    logic [29:0]     r_sum_lo;
    logic            r_carry_lo;
    logic [59:0]     r_rsp_sum;
    logic            r_rsp_cout;

    logic            w_grant_found;
    logic [IDW-1:0]  w_grant_id;
    int              w_idx;

    logic [29:0]     w_add_a;
    logic [29:0]     w_add_b;
    logic            w_add_cin;
    logic [29:0]     w_add_sum;
    logic            w_add_cout;

    // ------------------------------------------------------------------
    // Round-robin search starting at r_rr_ptr; first valid requester wins.
    // ------------------------------------------------------------------
    always_comb begin
        w_grant_found = 1'b0;
        w_grant_id    = '0;
        w_idx         = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = (int'(r_rr_ptr) + k) % NREQ;
            if (!w_grant_found && req_valid[w_idx]) begin
                w_grant_found = 1'b1;
                w_grant_id    = IDW'(w_idx);
            end
        end
    end

    // ------------------------------------------------------------------
    // Adder is fed only from registered operands. Outside HI the low half
    // is presented, so the inputs are always defined register values.
    // ------------------------------------------------------------------
    always_comb begin
        w_add_a   = r_a[29:0];
        w_add_b   = r_b[29:0];
        w_add_cin = r_cin;
        if (r_state == S_HI) begin
            w_add_a   = r_a[59:30];
            w_add_b   = r_b[59:30];
            w_add_cin = r_carry_lo;
        end
    end

    adder u_adder (
        .a    (w_add_a),
        .b    (w_add_b),
        .cin  (w_add_cin),
        .sum  (w_add_sum),
        .cout (w_add_cout)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (w_grant_found) w_next_state = S_LO;
            S_LO:   w_next_state = r_wide ? S_HI : S_RESP;
            S_HI:   w_next_state = S_RESP;
            S_RESP: if (rsp_ready) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        req_ready = '0;
        rsp_valid = 1'b0;
        case (r_state)
            S_IDLE: if (w_grant_found) req_ready[w_grant_id] = 1'b1;
            S_RESP: rsp_valid = 1'b1;
            default: ;
        endcase
    end

    assign rsp_id    = r_id;
    assign rsp_sum   = r_rsp_sum;
    assign rsp_cout  = r_rsp_cout;
    assign dbg_state = r_state;

    // ------------------------------------------------------------------
    // Datapath and round-robin pointer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr   <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_cin      <= 1'b0;
            r_wide     <= 1'b0;
            r_id       <= '0;
            r_sum_lo   <= '0;
            r_carry_lo <= 1'b0;
            r_rsp_sum  <= '0;
            r_rsp_cout <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_found) begin
                        // Operands are sampled only on the handshake cycle.
                        r_a    <= req_a[int'(w_grant_id)*60 +: 60];
                        r_b    <= req_b[int'(w_grant_id)*60 +: 60];
                        r_cin  <= req_cin[w_grant_id];
                        r_wide <= req_wide[w_grant_id];
                        r_id   <= w_grant_id;
                    end
                end
                S_LO: begin
                    r_sum_lo   <= w_add_sum;
                    r_carry_lo <= w_add_cout;
                    if (!r_wide) begin
                        r_rsp_sum  <= {30'b0, w_add_sum};
                        r_rsp_cout <= w_add_cout;
                    end
                end
                S_HI: begin
                    r_rsp_sum  <= {w_add_sum, r_sum_lo};
                    r_rsp_cout <= w_add_cout;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        // Next search starts just after the requester served.
                        if (r_id == IDW'(NREQ - 1)) r_rr_ptr <= '0;
                        else                        r_rr_ptr <= r_id + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_share_ctrl.sv
module tb_adder_share_ctrl;

  localparam int NREQ = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*60-1:0]  req_a;
  logic [NREQ*60-1:0]  req_b;
  logic [NREQ-1:0]     req_cin;
  logic [NREQ-1:0]     req_wide;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [1:0]          rsp_id;
  logic [59:0]         rsp_sum;
  logic                rsp_cout;
  logic [1:0]          dbg_state;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // expected response word: {id, cout, sum}
  logic [62:0] exp_q[$];

  adder_share_ctrl #(.NREQ(NREQ), .IDW(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .req_wide  (req_wide),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic apply_reset();
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_req(input int id, input logic [59:0] a, input logic [59:0] b,
                         input logic cin, input logic wide);
    req_a[id*60 +: 60] = a;
    req_b[id*60 +: 60] = b;
    req_cin[id]        = cin;
    req_wide[id]       = wide;
  endtask

  // Single transaction from one requester with rsp_ready=1. Latency is counted
  // from the acceptance cycle.
  task automatic do_txn(input int id, input logic [59:0] a, input logic [59:0] b,
                        input logic cin, input logic wide,
                        output bit got, output int lat, output logic [59:0] sum,
                        output logic cout, output logic [1:0] rid);
    got = 0; lat = 0; sum = '0; cout = 1'b0; rid = '0;
    set_req(id, a, b, cin, wide);
    req_valid     = '0;
    req_valid[id] = 1'b1;
    rsp_ready     = 1'b1;
    #1;
    for (int n = 0; n < 20 && !req_ready[id]; n++) step();
    if (!req_ready[id]) begin
      req_valid = '0;
      return;
    end
    step();
    req_valid = '0;
    lat = 1;
    for (int n = 0; n < 10 && !rsp_valid; n++) begin
      step();
      lat++;
    end
    if (rsp_valid) begin
      got  = 1;
      sum  = rsp_sum;
      cout = rsp_cout;
      rid  = rsp_id;
    end
    step();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, dbg_state} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got ready=%b v=%b id=%0d sum=%h cout=%b st=%0d exp all 0",
               req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, dbg_state);
    end
  endtask

  task automatic test_narrow();
    bit got; int lat; logic [59:0] s; logic c; logic [1:0] rid;
    do_txn(0, 60'h3FFFFFFF, 60'h1, 1'b0, 1'b0, got, lat, s, c, rid);
    checks++;
    if (!got || lat != 2 || rid !== 2'd0 || s !== 60'h0 || c !== 1'b1) begin
      errors++;
      $display("FAIL narrow_wrap got=%0d lat=%0d id=%0d sum=%h cout=%b exp lat=2 id=0 sum=0 cout=1",
               got, lat, rid, s, c);
    end
    // upper operand bits must be ignored for a narrow add
    do_txn(1, 60'hABCDEF0_00000005, 60'h5550000_0000000A, 1'b1, 1'b0, got, lat, s, c, rid);
    checks++;
    if (!got || lat != 2 || rid !== 2'd1 || s !== 60'h10 || c !== 1'b0) begin
      errors++;
      $display("FAIL narrow_ignore_hi got=%0d lat=%0d id=%0d sum=%h cout=%b exp lat=2 id=1 sum=10 cout=0",
               got, lat, rid, s, c);
    end
  endtask

  task automatic test_wide();
    bit got; int lat; logic [59:0] s; logic c; logic [1:0] rid;
    do_txn(2, 60'h000000003FFFFFFF, 60'h1, 1'b0, 1'b1, got, lat, s, c, rid);
    checks++;
    if (!got || lat != 3 || rid !== 2'd2 || s !== 60'h000000040000000 || c !== 1'b0) begin
      errors++;
      $display("FAIL wide_carry got=%0d lat=%0d id=%0d sum=%h cout=%b exp lat=3 id=2 sum=40000000 cout=0",
               got, lat, rid, s, c);
    end
    do_txn(2, 60'h800000000000000, 60'h800000000000000, 1'b1, 1'b1, got, lat, s, c, rid);
    checks++;
    if (!got || lat != 3 || rid !== 2'd2 || s !== 60'h1 || c !== 1'b1) begin
      errors++;
      $display("FAIL wide_overflow got=%0d lat=%0d id=%0d sum=%h cout=%b exp lat=3 id=2 sum=1 cout=1",
               got, lat, rid, s, c);
    end
  endtask

  task automatic test_round_robin();
    int exp_order[9] = '{0, 1, 2, 3, 0, 1, 3, 1, 3};
    int n_gnt = 0;
    int last_cyc = -1;
    int gid;
    apply_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 60'(i + 1), 60'(i * 3), 1'b0, 1'b0);
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    #1;
    for (int n = 0; n < 100 && n_gnt < 9; n++) begin
      if (req_ready != 0) begin
        gid = 0;
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) gid = i;
        checks++;
        if (!$onehot(req_ready) || gid != exp_order[n_gnt]) begin
          errors++;
          $display("FAIL rr_grant%0d got ready=%b exp id=%0d", n_gnt, req_ready, exp_order[n_gnt]);
        end
        if (last_cyc >= 0) begin
          checks++;
          if (cyc - last_cyc != 3) begin
            errors++;
            $display("FAIL rr_spacing got=%0d exp=3", cyc - last_cyc);
          end
        end
        last_cyc = cyc;
        n_gnt++;
      end
      step();
      if (n_gnt == 5) req_valid = 4'b1010;
    end
    checks++;
    if (n_gnt != 9) begin
      errors++;
      $display("FAIL rr_count got=%0d exp=9", n_gnt);
    end
    req_valid = '0;
    for (int n = 0; n < 4; n++) step();
  endtask

  task automatic test_backpressure();
    logic [59:0] s0;
    logic [1:0]  id0;
    set_req(0, 60'd123456, 60'd654321, 1'b0, 1'b0);
    req_valid = 4'b0001;
    rsp_ready = 1'b0;
    #1;
    for (int n = 0; n < 10 && !req_ready[0]; n++) step();
    step();
    req_valid = 4'hF;
    for (int n = 0; n < 5 && !rsp_valid; n++) step();
    #1;
    s0  = rsp_sum;
    id0 = rsp_id;
    checks++;
    if (rsp_valid !== 1'b1 || s0 !== 60'd777777 || id0 !== 2'd0) begin
      errors++;
      $display("FAIL bp_first got v=%b sum=%0d id=%0d exp v=1 sum=777777 id=0", rsp_valid, s0, id0);
    end
    for (int n = 0; n < 5; n++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_sum !== 60'd777777 || rsp_id !== 2'd0 || req_ready !== 4'b0) begin
        errors++;
        $display("FAIL bp_hold%0d got v=%b sum=%0d id=%0d ready=%b exp v=1 sum=777777 id=0 ready=0",
                 n, rsp_valid, rsp_sum, rsp_id, req_ready);
      end
      step();
    end
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0) begin
      errors++;
      $display("FAIL bp_release_same got ready=%b exp 0000", req_ready);
    end
    step();
    checks++;
    if (req_ready !== 4'b0010 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_next_grant got ready=%b v=%b exp ready=0010 v=0", req_ready, rsp_valid);
    end
    step();
    req_valid = '0;
    for (int n = 0; n < 3; n++) step();
  endtask

  task automatic test_reset_mid();
    int n_rsp0 = 0;
    int n_rsp3 = 0;
    set_req(0, 60'd10, 60'd20, 1'b0, 1'b0);
    set_req(3, 60'hFFFFFFFFFFFFFFF, 60'h1, 1'b0, 1'b1);
    req_valid = 4'b1000;
    rsp_ready = 1'b1;
    #1;
    for (int n = 0; n < 10 && !req_ready[3]; n++) step();
    step();
    req_valid = '0;
    step();
    checks++;
    if (dbg_state !== 2'd2) begin
      errors++;
      $display("FAIL rstmid_in_hi got state=%0d exp=2", dbg_state);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, dbg_state} !== '0) begin
      errors++;
      $display("FAIL rstmid_outputs got ready=%b v=%b id=%0d sum=%h cout=%b st=%0d exp all 0",
               req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, dbg_state);
    end
    req_valid = 4'b1001;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL rstmid_ptr got ready=%b exp 0001", req_ready);
    end
    step();
    req_valid = '0;
    for (int n = 0; n < 8; n++) begin
      if (rsp_valid) begin
        if (rsp_id == 2'd0 && rsp_sum == 60'd30) n_rsp0++;
        else n_rsp3++;
      end
      step();
    end
    checks++;
    if (n_rsp0 != 1 || n_rsp3 != 0) begin
      errors++;
      $display("FAIL rstmid_rsp got id0=%0d other=%0d exp id0=1 other=0", n_rsp0, n_rsp3);
    end
  endtask

  task automatic test_random();
    localparam int NTXN = 4000;
    int          model_ptr = 0;
    bit          busy = 0;
    int          acc_cyc = 0;
    int          acc_lat = 0;
    int          accepted = 0;
    int          exp_gnt;
    logic [3:0]  exp_ready;
    bit          exp_v;
    logic [63:0] t;
    logic [60:0] full;
    logic [30:0] nar;
    logic [62:0] obs;
    apply_reset();
    exp_q.delete();
    for (int n = 0; n < 60000 && (accepted < NTXN || busy); n++) begin
      if (accepted < NTXN) req_valid = 4'($urandom_range(0, 15));
      else                 req_valid = '0;
      for (int i = 0; i < NREQ; i++) begin
        t = {$urandom(), $urandom()};
        if ($urandom_range(0, 7) == 0) t = '1;
        req_a[i*60 +: 60] = t[59:0];
        t = {$urandom(), $urandom()};
        req_b[i*60 +: 60] = t[59:0];
        req_cin[i]  = 1'($urandom_range(0, 1));
        req_wide[i] = 1'($urandom_range(0, 1));
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      // arbitration model
      exp_gnt = -1;
      if (!busy)
        for (int k = 0; k < NREQ; k++)
          if (exp_gnt < 0 && req_valid[(model_ptr + k) % NREQ]) exp_gnt = (model_ptr + k) % NREQ;
      exp_ready = (exp_gnt >= 0) ? 4'(1 << exp_gnt) : 4'b0;
      checks++;
      if (req_ready !== exp_ready) begin
        errors++;
        $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, req_ready, exp_ready);
      end
      // response model
      exp_v = busy && ((cyc - acc_cyc) >= acc_lat);
      checks++;
      if (rsp_valid !== exp_v) begin
        errors++;
        $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, exp_v);
      end
      if (exp_v && exp_q.size() > 0) begin
        obs = {rsp_id, rsp_cout, rsp_sum};
        checks++;
        if (obs !== exp_q[0]) begin
          errors++;
          $display("FAIL rnd_data cyc=%0d got=%h exp=%h", cyc, obs, exp_q[0]);
        end
        if (rsp_ready) begin
          model_ptr = (int'(exp_q[0][62:61]) + 1) % NREQ;
          void'(exp_q.pop_front());
          busy = 0;
        end
      end
      if (exp_gnt >= 0) begin
        if (req_wide[exp_gnt]) begin
          full = {1'b0, req_a[exp_gnt*60 +: 60]} + {1'b0, req_b[exp_gnt*60 +: 60]}
               + 61'(req_cin[exp_gnt]);
          exp_q.push_back({2'(exp_gnt), full});
          acc_lat = 3;
        end else begin
          nar = {1'b0, req_a[exp_gnt*60 +: 30]} + {1'b0, req_b[exp_gnt*60 +: 30]}
              + 31'(req_cin[exp_gnt]);
          exp_q.push_back({2'(exp_gnt), nar[30], 30'b0, nar[29:0]});
          acc_lat = 2;
        end
        busy = 1;
        acc_cyc = cyc;
        accepted++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    checks++;
    if (accepted != NTXN || exp_q.size() != 0) begin
      errors++;
      $display("FAIL rnd_complete got accepted=%0d pending=%0d exp accepted=%0d pending=0",
               accepted, exp_q.size(), NTXN);
    end
    req_valid = '0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_cin   = '0;
    req_wide  = '0;
    rsp_ready = 1'b0;
    test_reset();
    test_narrow();
    test_wide();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
